// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad scanner and the keypad handler.
// Holds the key map, keycode constants, frame-class and FSM state enums,
// and small helpers for the row bit-vectors.
package keypad_pkg;

    // Keycodes of the non-digit keys
    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_EXEC  = 4'd11;
    localparam logic [3:0] KEY_DIV   = 4'd12;
    localparam logic [3:0] KEY_MUL   = 4'd13;
    localparam logic [3:0] KEY_SUB   = 4'd14;
    localparam logic [3:0] KEY_ADD   = 4'd15;

    // Key map: nibble at index {row, col} is the keycode of that switch
    localparam logic [63:0] KEY_MAP = 64'hCB0A_D987_E654_F321;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_ONE   = 2'd1,
        CLS_MULTI = 2'd2
    } frame_cls_e;

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } scan_state_e;

    // Keycode of the switch at index {row, col}
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        return KEY_MAP[{idx, 2'b00} +: 4];
    endfunction

    // Number of set bits in a 4-bit vector
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Index of the lowest set bit (only meaningful for one-hot input)
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins plus the strobe/code pair to the handler.
//   row_n     : keypad rows, active-low, asynchronous
//   col_n     : one-cold column drive
//   keystrobe : one-cycle pulse per accepted key
//   keycode   : code of the last accepted key
//   key_held  : accepted key still debounced-pressed
// master = scanner side, slave = board/handler side.
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       keystrobe;
    logic [3:0] keycode;
    logic       key_held;

    modport master (input row_n, output col_n, keystrobe, keycode, key_held);
    modport slave  (output row_n, input col_n, keystrobe, keycode, key_held);
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level debouncer. Holds the candidate (class + key
// index) and a saturating match counter updated at each frame end.
//   frame_end  : update strobe (last cycle of a frame)
//   cls_in     : class of the frame just completed
//   key_in     : key index {row, col} of the frame (0 unless ONE)
//   cand_*_c   : candidate as it will be after this cycle's update
//   stable_c   : counter will equal DEBOUNCE after this cycle's update
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_end,
    input  frame_cls_e cls_in,
    input  logic [3:0] key_in,
    output frame_cls_e cand_cls_c,
    output logic [3:0] cand_key_c,
    output logic       stable_c
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

    frame_cls_e       cand_cls_q, cand_cls_d;
    logic [3:0]       cand_key_q, cand_key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Candidate compare and saturating count
    always_comb begin
        cand_cls_d = cand_cls_q;
        cand_key_d = cand_key_q;
        cnt_d      = cnt_q;
        if (frame_end) begin
            if (cls_in == cand_cls_q && key_in == cand_key_q) begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cand_cls_d = cls_in;
                cand_key_d = key_in;
                cnt_d      = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_cls_q <= CLS_NONE;
            cand_key_q <= 4'd0;
            cnt_q      <= '0;
        end else begin
            cand_cls_q <= cand_cls_d;
            cand_key_q <= cand_key_d;
            cnt_q      <= cnt_d;
        end
    end

    assign cand_cls_c = cand_cls_d;
    assign cand_key_c = cand_key_d;
    assign stable_c   = (cnt_d == CNT_MAX);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad, debounces it and emits a
// one-cycle keystrobe with the accepted keycode.
//   clk, reset_n : clock, asynchronous active-low reset
//   kp (master)  : row_n in; col_n, keystrobe, keycode, key_held out
// Optional KEYPAD_REPEAT_EN: auto-repeat while the accepted key stays held
// (REPEAT_DELAY frames to the first repeat, REPEAT_RATE between later ones).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY = 125,
    parameter int unsigned REPEAT_RATE  = 25
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    keypad_scanner_if.master  kp
);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    logic [3:0]       sync1_q, sync2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       col_n_q, col_n_d;
    logic [1:0]       acc_n_q, acc_n_d;
    logic [3:0]       acc_key_q, acc_key_d;
    scan_state_e      state_q, state_d;
    logic             keystrobe_q, keystrobe_d;
    logic [3:0]       keycode_q, keycode_d;
    logic             key_held_q, key_held_d;

    logic             dwell_end, frame_end;
    logic [3:0]       row_act, tot_key, frame_key;
    logic [2:0]       row_cnt, tot;
    frame_cls_e       frame_cls, cand_cls_c;
    logic [3:0]       cand_key_c;
    logic             stable_c;

    assign dwell_end = (div_q == DIV_W'(SCAN_DIV - 1));
    assign frame_end = dwell_end && (col_q == 2'd3);

    // Column scan and per-frame accumulation of active switches
    always_comb begin
        row_act   = ~sync2_q;
        row_cnt   = popcount4(row_act);
        tot       = 3'(acc_n_q) + row_cnt;
        tot_key   = (row_cnt == 3'd1) ? {onehot_idx(row_act), col_q} : acc_key_q;
        frame_cls = CLS_MULTI;
        if (tot == 3'd0)      frame_cls = CLS_NONE;
        else if (tot == 3'd1) frame_cls = CLS_ONE;
        frame_key = (tot == 3'd1) ? tot_key : 4'd0;

        div_d     = div_q + DIV_W'(1);
        col_d     = col_q;
        col_n_d   = col_n_q;
        acc_n_d   = acc_n_q;
        acc_key_d = acc_key_q;
        if (dwell_end) begin
            div_d   = '0;
            col_d   = col_q + 2'd1;
            col_n_d = {col_n_q[2:0], col_n_q[3]};
            if (frame_end) begin
                acc_n_d   = 2'd0;
                acc_key_d = 4'd0;
            end else begin
                // Saturate at 2: anything above one switch is just MULTI
                acc_n_d   = (tot >= 3'd2) ? 2'd2 : 2'(tot);
                acc_key_d = tot_key;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_end  (frame_end),
        .cls_in     (frame_cls),
        .key_in     (frame_key),
        .cand_cls_c (cand_cls_c),
        .cand_key_c (cand_key_c),
        .stable_c   (stable_c)
    );

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
    logic [3:0]    held_key_q, held_key_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_tgt;
    logic          rep_first_q, rep_first_d;
    assign rep_tgt = rep_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
`endif

    // Press/release FSM; acts on the debouncer's post-update view at frame end
    always_comb begin
        state_d     = state_q;
        keystrobe_d = 1'b0;
        keycode_d   = keycode_q;
`ifdef KEYPAD_REPEAT_EN
        held_key_d  = held_key_q;
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
`endif
        if (frame_end) begin
            if (state_q == ST_RELEASED) begin
                if (stable_c && cand_cls_c == CLS_ONE) begin
                    state_d     = ST_PRESSED;
                    keystrobe_d = 1'b1;
                    keycode_d   = key_map(cand_key_c);
`ifdef KEYPAD_REPEAT_EN
                    held_key_d  = cand_key_c;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
`endif
                end
            end else begin
                if (stable_c && cand_cls_c == CLS_NONE) state_d = ST_RELEASED;
`ifdef KEYPAD_REPEAT_EN
                if (stable_c && cand_cls_c == CLS_ONE && cand_key_c == held_key_q) begin
                    if (rep_cnt_q + RW'(1) == rep_tgt) begin
                        keystrobe_d = 1'b1;
                        rep_cnt_d   = '0;
                        rep_first_d = 1'b0;
                    end else begin
                        rep_cnt_d   = rep_cnt_q + RW'(1);
                    end
                end else begin
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
                end
`endif
            end
        end
        key_held_d = (state_d == ST_PRESSED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            div_q       <= '0;
            col_q       <= 2'd0;
            col_n_q     <= 4'b1110;
            acc_n_q     <= 2'd0;
            acc_key_q   <= 4'd0;
            state_q     <= ST_RELEASED;
            keystrobe_q <= 1'b0;
            keycode_q   <= 4'd0;
            key_held_q  <= 1'b0;
        end else begin
            sync1_q     <= kp.row_n;
            sync2_q     <= sync1_q;
            div_q       <= div_d;
            col_q       <= col_d;
            col_n_q     <= col_n_d;
            acc_n_q     <= acc_n_d;
            acc_key_q   <= acc_key_d;
            state_q     <= state_d;
            keystrobe_q <= keystrobe_d;
            keycode_q   <= keycode_d;
            key_held_q  <= key_held_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_key_q  <= 4'd0;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            held_key_q  <= held_key_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    assign kp.col_n     = col_n_q;
    assign kp.keystrobe = keystrobe_q;
    assign kp.keycode   = keycode_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled 4x4 matrix (a pressed switch pulls its
// row low while its column is driven low) and compares the scanner against a
// frame-level reference model of debounce, accept, release and repeat.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 4 * SCAN_DIV;
`ifdef KEYPAD_REPEAT_EN
    localparam int REPEAT_DELAY = 5;
    localparam int REPEAT_RATE  = 2;
`endif

    logic        clk;
    logic        reset_n;
    logic [15:0] pressed;
    logic [3:0]  row_v;

    keypad_scanner_if kp ();

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
`endif
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kp      (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: switch {r,c} pressed pulls row r low while column c is low
    always_comb begin
        row_v = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.col_n[c]) row_v[r] = 1'b0;
    end
    assign kp.row_n = row_v;

    int checks = 0;
    int errors = 0;
    int n_strobe;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, one step per frame
    int KEY_TBL [16] = '{1, 2, 3, 15, 4, 5, 6, 14, 7, 8, 9, 13, 10, 0, 11, 12};
    int m_obs;      // -1 none, 0..15 single key index, 16 multiple
    int m_cnt;
    int m_key;
    int m_run;
    logic       m_held;
    logic       m_strobe;
    logic [3:0] m_code;

    task automatic model_reset();
        m_obs = -1; m_cnt = 0; m_key = 0; m_run = 0;
        m_held = 1'b0; m_strobe = 1'b0; m_code = 4'd0;
    endtask

    task automatic model_frame(input logic [15:0] keys);
        int  obs;
        bit  stable;
        obs = -1;
        if ($countones(keys) > 1) obs = 16;
        else for (int i = 0; i < 16; i++) if (keys[i]) obs = i;
        if (obs == m_obs) begin
            if (m_cnt < DEBOUNCE) m_cnt++;
        end else begin
            m_obs = obs;
            m_cnt = 1;
        end
        stable   = (m_cnt == DEBOUNCE);
        m_strobe = 1'b0;
        if (!m_held) begin
            if (stable && obs >= 0 && obs < 16) begin
                m_held = 1'b1; m_strobe = 1'b1; m_code = 4'(KEY_TBL[obs]);
                m_key = obs; m_run = 0;
            end
        end else begin
            if (stable && obs == -1) m_held = 1'b0;
`ifdef KEYPAD_REPEAT_EN
            if (stable && obs == m_key) begin
                m_run++;
                if (m_run == REPEAT_DELAY ||
                    (m_run > REPEAT_DELAY && (m_run - REPEAT_DELAY) % REPEAT_RATE == 0))
                    m_strobe = 1'b1;
            end else begin
                m_run = 0;
            end
`endif
        end
    endtask

    // One full frame with the given keys; entered and left at a negedge in cycle 0
    task automatic run_frame(input logic [15:0] keys);
        logic [3:0] exp_col;
        pressed = keys;
        for (int k = 0; k < FRAME; k++) begin
            exp_col = 4'hF;
            exp_col[k / SCAN_DIV] = 1'b0;
            chk("col_n", 32'(kp.col_n), 32'(exp_col));
            chk("keystrobe", 32'(kp.keystrobe), (k == 0) ? 32'(m_strobe) : 32'd0);
            chk("keycode", 32'(kp.keycode), 32'(m_code));
            chk("key_held", 32'(kp.key_held), 32'(m_held));
            if (kp.keystrobe) n_strobe++;
            @(posedge clk);
            @(negedge clk);
        end
        model_frame(keys);
    endtask

    task automatic hold(input logic [15:0] keys, input int frames);
        for (int f = 0; f < frames; f++) run_frame(keys);
    endtask

    // Asynchronous reset partway into a frame, keys still applied
    task automatic reset_mid(input logic [15:0] keys, input int ncyc);
        pressed = keys;
        repeat (ncyc) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_col", 32'(kp.col_n), 32'hE);
        chk("rst_mid_strobe", 32'(kp.keystrobe), 32'd0);
        chk("rst_mid_code", 32'(kp.keycode), 32'd0);
        chk("rst_mid_held", 32'(kp.key_held), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [15:0] kbit(input int r, input int c);
        logic [15:0] v;
        v = 16'd0;
        v[r*4+c] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [15:0] keys;
        int          nf;
        reset_n = 1'b1;
        pressed = 16'd0;
        n_strobe = 0;
        model_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_col", 32'(kp.col_n), 32'hE);
        chk("rst_strobe", 32'(kp.keystrobe), 32'd0);
        chk("rst_code", 32'(kp.keycode), 32'd0);
        chk("rst_held", 32'(kp.key_held), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        hold(16'd0, 2);

        // Single press of (row1,col2) -> keycode 6
        n_strobe = 0;
        hold(kbit(1, 2), 6);
        hold(16'd0, 4);
        chk("n_single", 32'(n_strobe), 32'd1);

        // Bounce on (row0,col3), then a clean hold -> keycode 15
        n_strobe = 0;
        for (int f = 0; f < 8; f++) run_frame((f % 2 == 0) ? kbit(0, 3) : 16'd0);
        chk("n_bounce", 32'(n_strobe), 32'd0);
        hold(kbit(0, 3), 3);
        hold(16'd0, 4);
        chk("n_bounce_hold", 32'(n_strobe), 32'd1);

        // Two keys on row3, then col0 released -> keycode 11
        n_strobe = 0;
        hold(kbit(3, 0) | kbit(3, 2), 5);
        chk("n_multi", 32'(n_strobe), 32'd0);
        hold(kbit(3, 2), 4);
        hold(16'd0, 4);
        chk("n_multi_rel", 32'(n_strobe), 32'd1);

        // Roll-over: 5 then 9 without releasing 5; later a clean press of 9
        n_strobe = 0;
        hold(kbit(1, 1), 4);
        hold(kbit(1, 1) | kbit(2, 2), 3);
        hold(kbit(2, 2), 4);
        chk("n_rollover", 32'(n_strobe), 32'd1);
        hold(16'd0, 3);
        hold(kbit(2, 2), 4);
        hold(16'd0, 4);
        chk("n_repress", 32'(n_strobe), 32'd2);

        // Long hold of key 0
        n_strobe = 0;
        hold(kbit(3, 1), 15);
        hold(16'd0, 4);
`ifdef KEYPAD_REPEAT_EN
        chk("n_long_hold", 32'(n_strobe), 32'd5);
`else
        chk("n_long_hold", 32'(n_strobe), 32'd1);
`endif

        // Reset while a key is accepted and still held
        hold(kbit(0, 0), 4);
        reset_mid(kbit(0, 0), 6);
        n_strobe = 0;
        hold(kbit(0, 0), 4);
        hold(16'd0, 4);
        chk("n_after_reset", 32'(n_strobe), 32'd1);

        // Random hold patterns
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 3))
                0:       keys = 16'd0;
                1, 2:    keys = 16'd1 << $urandom_range(0, 15);
                default: keys = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            endcase
            nf = $urandom_range(1, 5);
            hold(keys, nf);
        end
        hold(16'd0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Scans a 4x4 matrix keypad and debounces it.
- Produces the single-cycle `keystrobe` / 4-bit `keycode` pair that the keypad handler decodes into digit, clear, execute and operator strobes.
- Sits between the board keypad pins and the keypad handler, in the same clock domain as the calculator core.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven (dwell); must be ≥2.
- `DEBOUNCE`, default 4: consecutive identical frames needed for a stable state; must be 1–15.
- `REPEAT_DELAY`, default 125: frames held before the first auto-repeat. Used only with `KEYPAD_REPEAT_EN`.
- `REPEAT_RATE`, default 25: frames between later repeats. Used only with `KEYPAD_REPEAT_EN`.
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `row_n` input 4: keypad rows, active-low with external pull-ups, asynchronous to `clk`.
- `col_n` output 4: column drive, one-cold.
- `keystrobe` output 1: one-cycle pulse when a new key is accepted.
- `keycode` output 4: code of the last accepted key; held between strobes.
- `key_held` output 1: high while the accepted key is debounced-pressed.

## Operation
- **Row synchronizer:** `row_n` passes through a 2-flop synchronizer before use.
- **Column scan:** the scan counter drives column c low (`col_n = ~(1<<c)`) for `SCAN_DIV` cycles, cycling c = 0,1,2,3,0,…
- **Row sampling:** synchronized rows are sampled on the last cycle of each dwell.
- **Frame:** one frame is 4 dwells. Frame end is the last cycle of the column-3 dwell.
- **Frame classification:** NONE (0 active switches), ONE (exactly 1 active switch, carrying row/col), MULTI (≥2).
- **Key map** (row, col0..col3):
  - row0: 1, 2, 3, 15 (+)
  - row1: 4, 5, 6, 14 (−)
  - row2: 7, 8, 9, 13 (×)
  - row3: 10 (clear), 0, 11 (=), 12 (÷)
- **Debounce:** at frame end, compare the class and code against the candidate register.
  - Equal: `cnt` saturating-increments to `DEBOUNCE`.
  - Different: candidate is replaced and `cnt` is set to 1.
  - Stable means `cnt == DEBOUNCE`.
- **FSM states:** RELEASED and PRESSED.
- **From RELEASED:**
  - Stable ONE(k): `keycode <= map(k)`, pulse `keystrobe` for one cycle, go to PRESSED.
  - Stable NONE or MULTI: stay in RELEASED.
- **From PRESSED:**
  - Stable NONE: go to RELEASED.
  - Stable MULTI, or stable ONE of a different key: stay in PRESSED with no strobe. A key must be fully released before the next accept (no roll-over).
- **`key_held`:** equals (state == PRESSED).
- **`keycode`:** changes only in the cycle `keystrobe` is asserted.
- **Reset** (any time, including mid-press or mid-debounce):
  - `col_n = 4'b1110`, `keystrobe = 0`, `keycode = 0`, `key_held = 0`.
  - Scan counter = 0, candidate = NONE, `cnt = 0`, state = RELEASED, synchronizer flops = 1.
  - A key held through reset deassertion is accepted after `DEBOUNCE` frames, like a fresh press.

## Timing
- **Column switching:** `col_n` changes on the cycle after the previous dwell's sample cycle. Rows have `SCAN_DIV−1` cycles to settle, minus 2 synchronizer cycles.
- **Frame length:** `4*SCAN_DIV` cycles. No gap between frames.
- **Press latency:** a press is visible from frame f. `keystrobe` asserts on the cycle after the end of frame f+`DEBOUNCE`−1, with `keycode` valid in that same cycle.
- **Release latency:** same formula for leaving PRESSED.
- **Pulse width:** `keystrobe` is never wider than 1 cycle. Consecutive strobes are at least `2*DEBOUNCE` frames apart without repeat.
- **Counter width:** `cnt` is 4 bits and never wraps. The scan counter wraps from `SCAN_DIV−1` to 0.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In PRESSED, a frame counter runs while the candidate stays stable ONE of the accepted key.
  - `keystrobe` re-pulses with the same `keycode` after `REPEAT_DELAY` frames, then every `REPEAT_RATE` frames.
  - The counter clears on leaving PRESSED or when the candidate changes.
- `KEYPAD_REPEAT_EN` undefined:
  - Exactly one strobe per press.
  - No repeat counter logic and no `REPEAT_*` use.

## Structure
- **Shared package `keypad_pkg`:**
  - Key map table.
  - Keycode constants: `KEY_CLEAR = 10`, `KEY_EXEC = 11`, `KEY_DIV = 12`, `KEY_MUL = 13`, `KEY_SUB = 14`, `KEY_ADD = 15`. The keypad handler uses these too.
  - Frame-class enum (NONE/ONE/MULTI) and FSM state enum.
- **Sub-module `keypad_debounce`:** candidate register, `cnt`, stable flag; generic over `DEBOUNCE`. The scan and FSM live in the top.

## Test plan
Bench parameters: `SCAN_DIV = 4`, `DEBOUNCE = 3`; frame = 16 cycles. The bench models the matrix by pulling a row low when its column is driven low.
- **Reset:** assert `reset_n = 0` mid-scan → `col_n = 1110`, `keystrobe = 0`, `keycode = 0`, `key_held = 0`. Release reset → `col_n` steps 1110, 1101, 1011, 0111 every 4 cycles.
- **Single press:** press (row1, col2) from frame 0 for 6 frames → exactly one `keystrobe` on the cycle after frame 2 ends, `keycode = 6`, `key_held = 1`. `key_held` falls 3 frames after release.
- **Bounce rejection:** (row0, col3) toggles pressed/released every frame for 8 frames → no `keystrobe`. Then held 3 frames → one strobe, `keycode = 15`.
- **Multi-key:** (row3, col0) and (row3, col2) pressed together for 5 frames → no strobe. Release col0 → strobe with `keycode = 11` after 3 frames.
- **Roll-over and re-press:** press 5, then press 9 before releasing 5 → one strobe (`keycode = 5`) only. Release all for 3 frames, press 9 → strobe, `keycode = 9`.
- **Repeat:** with `KEYPAD_REPEAT_EN`, `REPEAT_DELAY = 5`, `REPEAT_RATE = 2`, hold 0 for 15 frames → strobes at accept, +5 frames, then every 2 frames. All have `keycode = 0`.
